// File: rtl/brick_display_pkg.sv
// Shared types and constants for the score display: FSM states, blank code, limits.
// Latency: none (declarations only).
// Backpressure: not applicable.
package brick_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         MAX_SCORE  = 9999;
  localparam int         NUM_DIGITS = 4;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-add-3), input saturated to MAX_SCORE when latched.
// Latency: value latched on start, one shift per cycle for BIN_W cycles; done flags the final shift.
// Backpressure: none; a start while running restarts the conversion (the caller gates it).
module bin2bcd_serial
  import brick_display_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [15:0]      bcd_q;
  logic [BIN_W-1:0] bin_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [BIN_W-1:0] sat_val;
  logic [15:0]      bcd_adj;

  assign sat_val = (int'(bin) > MAX_SCORE) ? BIN_W'(MAX_SCORE) : bin;

  assign bcd_adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                    add3(bcd_q[7:4]),   add3(bcd_q[3:0])};

  // done is high during the cycle whose closing edge performs the last shift,
  // so bcd is final from the following cycle on.
  assign done = run_q && (cnt_q == CW'(BIN_W - 1));
  assign bcd  = bcd_q;

  // Latch and saturate on start, then correct-and-shift once per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      bcd_q <= '0;
      bin_q <= sat_val;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      bcd_q <= {bcd_adj[14:0], bin_q[BIN_W-1]};
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/digital_7.sv
// Hex-code to 7-segment decoder; bit order {b,c,d,a,e,f,g}, active-high segments.
// Latency: combinational.
// Backpressure: not applicable; codes 10..15 (including the blank code) light nothing.
module digital_7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Segment lookup for decimal digits; everything else is dark.
  always_comb begin
    seg = 7'b0000000;
    case (digit)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b1100000;
      4'd2: seg = 7'b1011101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b1100011;
      4'd5: seg = 7'b0111011;
      4'd6: seg = 7'b0111111;
      4'd7: seg = 7'b1101000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/score_scan_ctrl.sv
// Score display controller: BCD-converts a binary score and scans 4 digits through one shared decoder.
// Latency: new digits land BIN_W+1 cycles after the accepting edge; display/digit_sel are one register stage.
// Backpressure: score_valid accepted only while ready; loads during a conversion are dropped. Optional SCORE_LEADING_ZERO_BLANK_EN.
module score_scan_ctrl
  import brick_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  score_in,
  input  logic              score_valid,
  output logic              ready,
  output logic              busy,
  output logic [6:0]        display,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

  state_t          state_q, state_d;
  logic            start;
  logic            conv_done;
  logic [15:0]     bcd;
  logic [3:0]      dig_q [DIGITS];
  logic [PW-1:0]   presc_q;
  logic [IW-1:0]   scan_idx_q;
  logic            blank;
  logic [3:0]      code;
  logic [6:0]      seg;

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign start = ready & score_valid;

  bin2bcd_serial #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (score_in),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept, wait for the last shift, commit for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (score_valid)  state_d = CONVERT;
      CONVERT: if (conv_done)    state_d = COMMIT;
      COMMIT:                    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Digit bank updates only on the COMMIT edge, so the scanner never sees a partial value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= 4'd0;
    end else if (state_q == COMMIT) begin
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= bcd[4*i +: 4];
    end
  end

  // Slot prescaler and scan index, free-running and independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      scan_idx_q <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q    <= '0;
      scan_idx_q <= (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic hz;
    blank = 1'b0;
    hz    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hz = hz & (dig_q[i] == 4'd0);
      if (IW'(i) == scan_idx_q) blank = hz;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign code = blank ? BLANK_CODE : dig_q[scan_idx_q];

  digital_7 u_dec (
    .digit (code),
    .seg   (seg)
  );

  // Output stage: segments and enable registered together; enable dark in each slot's first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display   <= '0;
      digit_sel <= '0;
    end else begin
      display   <= seg;
      digit_sel <= (presc_q == '0) ? '0 : (DIGITS'(1) << scan_idx_q);
    end
  end

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Bench for score_scan_ctrl: directed and random score loads against an arithmetic display model.
// Latency: checks every cycle, 1 time unit after the rising edge.
// Backpressure: model tracks ready from the accept edge plus BIN_W+1 cycles.
module tb_score_scan_ctrl;

  localparam int SD    = 4;
  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [BIN_W-1:0] score_in = '0;
  logic             score_valid = 1'b0;
  logic             ready, busy;
  logic [6:0]       display;
  logic [3:0]       digit_sel;

  int passed = 0;
  int total  = 0;

  // Model state: cycles since reset release, shown value, pending value, commit countdown.
  int t      = 0;
  int cur    = 0;
  int pend   = 0;
  int left   = 0;
  bit mready = 1'b1;

  score_scan_ctrl #(
    .DIGITS   (4),
    .BIN_W    (BIN_W),
    .SCAN_DIV (SD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .score_in    (score_in),
    .score_valid (score_valid),
    .ready       (ready),
    .busy        (busy),
    .display     (display),
    .digit_sel   (digit_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, got, exp, t);
  endtask

  function automatic int pow10(input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r *= 10;
    return r;
  endfunction

  // Which code the decoder should see for digit i of value v.
  function automatic int code_of(input int v, input int i);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (i > 0 && v < pow10(i)) return 15;
`endif
    return (v / pow10(i)) % 10;
  endfunction

  // Conventional abcdefg shapes, then reordered to the board wiring {b,c,d,a,e,f,g}.
  function automatic logic [6:0] seg_of(input int c);
    logic [6:0] s;
    case (c)
      0: s = 7'b1111110;  1: s = 7'b0110000;  2: s = 7'b1101101;
      3: s = 7'b1111001;  4: s = 7'b0110011;  5: s = 7'b1011011;
      6: s = 7'b1011111;  7: s = 7'b1110000;  8: s = 7'b1111111;
      9: s = 7'b1111011;  default: s = 7'b0000000;
    endcase
    return {s[5], s[4], s[3], s[6], s[2], s[1], s[0]};
  endfunction

  // One clock: predict outputs from the pre-edge state, advance the model, compare.
  task automatic tick();
    int pos, slot;
    logic [3:0] exp_sel;
    logic [6:0] exp_disp;
    pos      = t % SD;
    slot     = (t / SD) % 4;
    exp_sel  = (pos == 0) ? 4'b0000 : 4'(1 << slot);
    exp_disp = seg_of(code_of(cur, slot));
    if (score_valid && mready) begin
      pend   = (int'(score_in) > 9999) ? 9999 : int'(score_in);
      left   = BIN_W + 1;
      mready = 1'b0;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin
        cur    = pend;
        mready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    t++;
    check("digit_sel", 32'(digit_sel), 32'(exp_sel));
    if (exp_sel != 4'b0000) check("display", 32'(display), 32'(exp_disp));
    check("ready", 32'(ready), 32'(mready));
    check("busy", 32'(busy), 32'(!mready));
  endtask

  task automatic load(input int v);
    score_in    = BIN_W'(v);
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!mready && n < 40) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(mready), 32'(1));
  endtask

  task automatic model_reset();
    t = 0; cur = 0; pend = 0; left = 0; mready = 1'b1;
  endtask

  initial begin
    int n;
    int v;
    // Reset held for 10 cycles: outputs at reset values throughout.
    repeat (10) begin
      @(posedge clk);
      #1;
      check("rst_display", 32'(display), 32'(0));
      check("rst_digit_sel", 32'(digit_sel), 32'(0));
      check("rst_ready", 32'(ready), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
    end
    rst = 1'b0;
    model_reset();

    // Idle scan of the all-zero bank over more than one frame.
    repeat (20) tick();

    // 1234: ready must stay low for exactly BIN_W+1 cycles after the accept edge.
    load(1234);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("ready_low_cycles", 32'(n), 32'(BIN_W + 1));
    repeat (20) tick();

    // Saturation plus a load attempt during conversion that must be dropped.
    load(12000);
    repeat (3) tick();
    load(5);
    wait_ready();
    repeat (20) tick();

    // Single digit: leading zeros blank or show depending on the build.
    load(7);
    wait_ready();
    repeat (20) tick();

    // Reset five cycles into a conversion: nothing committed, bank back to zero.
    load(4321);
    repeat (4) tick();
    rst = 1'b1;
    #2;
    check("mid_rst_ready", 32'(ready), 32'(1));
    check("mid_rst_display", 32'(display), 32'(0));
    check("mid_rst_digit_sel", 32'(digit_sel), 32'(0));
    #1;
    rst = 1'b0;
    model_reset();
    repeat (20) tick();

    // Boundary values, then random loads with held valid and stray pulses.
    load(9999);  wait_ready(); repeat (17) tick();
    load(10000); wait_ready(); repeat (17) tick();
    load(0);     wait_ready(); repeat (17) tick();
    load(1000);  wait_ready(); repeat (17) tick();
    for (int it = 0; it < 25; it++) begin
      v = int'($urandom_range(0, 16383));
      score_in    = BIN_W'(v);
      score_valid = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      score_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 8)) tick();
        load(int'($urandom_range(0, 16383)));
      end
      wait_ready();
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (16) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/score_scan_ctrl.md
# score_scan_ctrl

Time-multiplexed controller that shares a single `digital_7` segment-decoder instance across the four common-cathode digits of the score display. It accepts a binary score, converts it to BCD with a multi-cycle shift-add-3 sequence, and holds the result in a digit register bank. It scans the digits at a programmable refresh rate, driving one decoded segment pattern plus a one-hot digit enable. It sits between the game-logic score counter and the board's 7-segment pins.

## Interface
- `DIGITS`, 4: number of scanned digits; fixed at 4 in this revision.
- `BIN_W`, 14: width of the binary score input.
- `SCAN_DIV`, 50000: clock cycles per digit slot; legal minimum is 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `score_in`  in  BIN_W  binary score, sampled when `score_valid & ready`.
- `score_valid`  in  1  load request, single-cycle or held.
- `ready`  out  1  high when idle and able to accept a new score.
- `busy`  out  1  high while a conversion is in progress; equal to `~ready`.
- `display`  out  7  registered segment pattern from the shared `digital_7` decoder.
- `digit_sel`  out  DIGITS  registered one-hot digit enable, active-high; bit 0 is the least significant digit.

## Operation
- **Reset values:** `display`=0, `digit_sel`=0, `ready`=1, `busy`=0. Digit registers, scan index and prescaler all reset to 0.
- **FSM states:** IDLE, CONVERT, COMMIT.
  - IDLE → CONVERT on `score_valid & ready`. `score_in` is latched at that edge.
  - CONVERT runs exactly BIN_W cycles of double-dabble (add 3 to any nibble ≥5, then shift left 1). It then goes to COMMIT.
  - COMMIT lasts one cycle. It writes all 4 BCD nibbles to the digit registers atomically, then returns to IDLE.
- **Saturation:** a latched value greater than 9999 is replaced by 9999 before conversion.
- **Load while busy:** `score_valid` during CONVERT or COMMIT is ignored, not queued.
- **Scanning:**
  - The scanner runs independently of the FSM. During conversion it keeps showing the previously committed digits.
  - The prescaler counts 0..SCAN_DIV-1. When it wraps, the scan index advances and wraps from DIGITS-1 to 0.
- **Anti-ghosting:** in the first cycle of every slot (prescaler==0), `digit_sel` is driven to all zeros. For the remaining SCAN_DIV-1 cycles it is the one-hot of the scan index.
- **Decode:** the decoder input is the digit register selected by the scan index, or the blank code 4'hF when blanking applies. Code 4'hF decodes to 7'b0000000.
- **Mid-operation reset:** `rst` asserted during CONVERT aborts the conversion. The digit registers return to 0 and no partial value is ever committed.

## Timing
- Latency from the accepting edge E to new digit registers is E+BIN_W+1, i.e. the COMMIT edge. `ready` returns high after that same edge.
- `display` and `digit_sel` are both registered in the same stage and are always mutually aligned.
- The first display of a new value appears one cycle after COMMIT, on whichever digit is being scanned at that time.
- A full refresh frame takes DIGITS×SCAN_DIV cycles.

## Configuration
- `SCORE_LEADING_ZERO_BLANK_EN` defined: leading-zero blanking is on.
  - Zero digits above the most significant nonzero digit decode as blank (4'hF).
  - Digit 0 is never blanked, so score 0 shows a single "0".
- Macro undefined: all four digits always show their value, including leading zeros.

## Structure
- Shared package `brick_display_pkg` holds:
  - the state enum (IDLE, CONVERT, COMMIT);
  - `BLANK_CODE` = 4'hF;
  - `MAX_SCORE` = 9999;
  - `NUM_DIGITS` = 4.
- One natural sub-module, `bin2bcd_serial`, contains the latch, saturation, shift-add-3 datapath and cycle counter. It exposes `start`, `done` and a 16-bit BCD result.
- The top level keeps the FSM glue, digit registers, prescaler, scan index, blanking logic and one `digital_7` instance.

## Test plan
- **Reset:** assert `rst` → `display`=0, `digit_sel`=0, `ready`=1. Hold for 10 cycles → outputs stay unchanged.
- **Conversion:**
  - Set SCAN_DIV=4 and load 1234.
  - `ready` is low for exactly 15 cycles.
  - The digit registers then hold 4,3,2,1 (LSD first).
  - In slot 0, `display`=7'b1100011 with `digit_sel`=4'b0001.
- **Scan:** with SCAN_DIV=4, `digit_sel` follows 0000, 0001, 0001, 0001, 0000, 0010, … and returns to 0001 after 16 cycles.
- **Saturation and ignored load:**
  - Load 12000 → the digits read 9,9,9,9.
  - Pulse `score_valid` with value 5 during CONVERT → it is ignored and the digits remain 9999.
- **Blanking:** load 7.
  - With the macro defined: digits 3..1 give `display`=7'b0000000, and digit 0 gives 7'b1101000.
  - Without the macro: digits 3..1 give 7'b1111110.
- **Mid-conversion reset:** load 4321, then assert `rst` 5 cycles later → the digit registers are 0, `ready`=1, and the next frame shows all digits as 0.
